// File: rtl/map_dma_eng_if.sv
`default_nettype none
// ============================================================================
// Module   : map_dma_eng_if
// Purpose  : Bundles the config, stream and memory-bus signals of the
//            map_dma_eng DMA engine.
// Modports : slave  - engine side (consumes config/stream input, drives the
//                     memory bus and the stream output)
//            master - host/environment side (the opposite directions)
// Signals  : cfg_we/cfg_ch/cfg_reg/cfg_dat    config write port
//            ch_busy/ch_done/dma_req          per-channel status
//            wr_dat/wr_vld/wr_rdy             stream-to-memory beats
//            rd_dat/rd_vld/rd_rdy/stream_ch   memory-to-stream beats
//            mem_addr/mem_do/mem_di/mem_ce_*/mem_oe/mem_we  memory bus
// Revision : 1.0 - initial release
// ============================================================================
interface map_dma_eng_if #(
  parameter int CH_NUM = 2,
  parameter int AW     = 23
);
  logic              cfg_we;
  logic [1:0]        cfg_ch;
  logic [1:0]        cfg_reg;
  logic [23:0]       cfg_dat;
  logic [CH_NUM-1:0] ch_busy;
  logic [CH_NUM-1:0] ch_done;
  logic [7:0]        wr_dat;
  logic              wr_vld;
  logic              wr_rdy;
  logic [7:0]        rd_dat;
  logic              rd_vld;
  logic              rd_rdy;
  logic [1:0]        stream_ch;
  logic [AW-1:0]     mem_addr;
  logic [7:0]        mem_do;
  logic [7:0]        mem_di;
  logic              mem_ce_prg;
  logic              mem_ce_chr;
  logic              mem_ce_srm;
  logic              mem_oe;
  logic              mem_we;
  logic              dma_req;

  modport slave (
    input  cfg_we, cfg_ch, cfg_reg, cfg_dat, wr_dat, wr_vld, rd_rdy, mem_di,
    output ch_busy, ch_done, wr_rdy, rd_dat, rd_vld, stream_ch, mem_addr,
           mem_do, mem_ce_prg, mem_ce_chr, mem_ce_srm, mem_oe, mem_we, dma_req
  );

  modport master (
    output cfg_we, cfg_ch, cfg_reg, cfg_dat, wr_dat, wr_vld, rd_rdy, mem_di,
    input  ch_busy, ch_done, wr_rdy, rd_dat, rd_vld, stream_ch, mem_addr,
           mem_do, mem_ce_prg, mem_ce_chr, mem_ce_srm, mem_oe, mem_we, dma_req
  );
endinterface
`default_nettype wire

// File: rtl/map_dma_eng.sv
`default_nettype none
// ============================================================================
// Module   : map_dma_eng
// Purpose  : Multi-channel byte DMA between a host stream port and the
//            PRG/CHR/SRM memories. Busy channels are serviced one access at
//            a time under round-robin arbitration.
// Ports    : clk, rst (asynchronous, active-high)
//            bus (map_dma_eng_if.slave): config port, channel status,
//            write/read stream handshakes, memory bus with CE/OE/WE strobes.
// Option   : MAP_DMA_FILL_EN - ctrl[5] with dir=1 writes the constant
//            ctrl[15:8] instead of stream data.
// Revision : 1.0 - initial release
// ============================================================================
module map_dma_eng #(
  parameter int CH_NUM  = 2,
  parameter int AW      = 23,
  parameter int LW      = 16,
  parameter int MEM_LAT = 2
) (
  input  logic          clk,
  input  logic          rst,
  map_dma_eng_if.slave  bus
);
  // Channel storage is always sized for the maximum channel count so the
  // 2-bit grant index never runs past an array; unused slots stay idle.
  localparam int CH_MAX = 4;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_ARB     = 3'd1,
    S_WAIT_WR = 3'd2,
    S_ACC     = 3'd3,
    S_HOLD    = 3'd4,
    S_NEXT    = 3'd5
  } state_t;

  state_t          state_q, state_d;
  logic [1:0]      gnt_q, gnt_d;        // channel owning the current access
  logic [1:0]      ptr_q, ptr_d;        // first channel to consider next ARB
  logic [2:0]      lat_q, lat_d;
  logic [AW-1:0]   mem_addr_q, mem_addr_d;
  logic [7:0]      mem_do_q, mem_do_d;
  logic [7:0]      rd_dat_q, rd_dat_d;
  logic [1:0]      stream_ch_q, stream_ch_d;

  logic [AW-1:0]   addr_q [CH_MAX];
  logic [AW-1:0]   addr_d [CH_MAX];
  logic [LW-1:0]   len_q  [CH_MAX];
  logic [LW-1:0]   len_d  [CH_MAX];
  logic [1:0]      tgt_q  [CH_MAX];
  logic [1:0]      tgt_d  [CH_MAX];
  logic [CH_MAX-1:0] dir_q, dir_d, busy_q, busy_d, done_q, done_d, abort_q, abort_d;
`ifdef MAP_DMA_FILL_EN
  logic [CH_MAX-1:0] fill_q, fill_d;
  logic [7:0]      fdat_q [CH_MAX];
  logic [7:0]      fdat_d [CH_MAX];
`endif

  logic            arb_hit;
  logic [1:0]      arb_ch, arb_idx;
  logic            adv_w, fin_w, acc_w, wr_rdy_w, rd_vld_w;
  logic            unused_ok;

  assign unused_ok = ^bus.cfg_dat;

  // Round-robin search starting at ptr_q.
  always_comb begin
    arb_hit = 1'b0;
    arb_ch  = ptr_q;
    arb_idx = 2'd0;
    for (int k = 0; k < CH_NUM; k++) begin
      arb_idx = 2'((int'(ptr_q) + k) % CH_NUM);
      if (!arb_hit && busy_q[arb_idx]) begin
        arb_hit = 1'b1;
        arb_ch  = arb_idx;
      end
    end
  end

  // Access sequencer.
  always_comb begin
    state_d     = state_q;
    gnt_d       = gnt_q;
    ptr_d       = ptr_q;
    lat_d       = lat_q;
    mem_addr_d  = mem_addr_q;
    mem_do_d    = mem_do_q;
    rd_dat_d    = rd_dat_q;
    stream_ch_d = stream_ch_q;
    adv_w       = 1'b0;
    fin_w       = 1'b0;
    acc_w       = 1'b0;
    wr_rdy_w    = 1'b0;
    rd_vld_w    = 1'b0;
    case (state_q)
      S_IDLE: if (|busy_q) state_d = S_ARB;
      S_ARB: begin
        if (arb_hit) begin
          gnt_d       = arb_ch;
          ptr_d       = 2'((int'(arb_ch) + 1) % CH_NUM);
          stream_ch_d = arb_ch;
          mem_addr_d  = addr_q[arb_ch];
          lat_d       = 3'd0;
          if (!dir_q[arb_ch]) begin
            state_d = S_ACC;
          end else begin
`ifdef MAP_DMA_FILL_EN
            if (fill_q[arb_ch]) begin
              mem_do_d = fdat_q[arb_ch];
              state_d  = S_ACC;
            end else begin
              state_d  = S_WAIT_WR;
            end
`else
            state_d = S_WAIT_WR;
`endif
          end
        end else begin
          state_d = S_IDLE;
        end
      end
      S_WAIT_WR: begin
        wr_rdy_w = 1'b1;
        if (bus.wr_vld) begin
          mem_do_d = bus.wr_dat;
          state_d  = S_ACC;
        end else if (abort_q[gnt_q]) begin
          // Aborted while starved: finish without touching memory.
          fin_w   = 1'b1;
          state_d = S_IDLE;
        end
      end
      S_ACC: begin
        acc_w = 1'b1;
        if (lat_q == 3'(MEM_LAT - 1)) begin
          if (dir_q[gnt_q]) begin
            state_d = S_NEXT;
          end else begin
            rd_dat_d = bus.mem_di;
            state_d  = S_HOLD;
          end
        end else begin
          lat_d = lat_q + 3'd1;
        end
      end
      S_HOLD: begin
        rd_vld_w = 1'b1;
        if (bus.rd_rdy) state_d = S_NEXT;
      end
      S_NEXT: begin
        adv_w = 1'b1;
        if (len_q[gnt_q] == LW'(1) || abort_q[gnt_q]) fin_w = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Channel registers: sequencer updates first, then config writes so a
  // ctrl write's done-clear overrides a same-cycle completion.
  always_comb begin
    busy_d  = busy_q;
    done_d  = done_q;
    dir_d   = dir_q;
    abort_d = abort_q;
`ifdef MAP_DMA_FILL_EN
    fill_d  = fill_q;
`endif
    for (int i = 0; i < CH_MAX; i++) begin
      addr_d[i] = addr_q[i];
      len_d[i]  = len_q[i];
      tgt_d[i]  = tgt_q[i];
`ifdef MAP_DMA_FILL_EN
      fdat_d[i] = fdat_q[i];
`endif
      if (adv_w && gnt_q == 2'(i)) begin
        addr_d[i] = addr_q[i] + AW'(1);
        len_d[i]  = len_q[i] - LW'(1);
      end
      if (fin_w && gnt_q == 2'(i)) begin
        busy_d[i] = 1'b0;
        done_d[i] = 1'b1;
      end
      if (bus.cfg_we && bus.cfg_ch == 2'(i) && i < CH_NUM) begin
        case (bus.cfg_reg)
          2'd0: if (!busy_q[i]) addr_d[i] = bus.cfg_dat[AW-1:0];
          2'd1: if (!busy_q[i]) len_d[i]  = bus.cfg_dat[LW-1:0];
          2'd2: begin
            done_d[i] = 1'b0;
            if (!busy_q[i]) begin
              dir_d[i] = bus.cfg_dat[1];
              tgt_d[i] = bus.cfg_dat[3:2];
`ifdef MAP_DMA_FILL_EN
              fill_d[i] = bus.cfg_dat[5];
              fdat_d[i] = bus.cfg_dat[15:8];
`endif
              if (bus.cfg_dat[0]) begin
                if (len_q[i] == '0 || bus.cfg_dat[3:2] == 2'd3) done_d[i] = 1'b1;
                else                                             busy_d[i] = 1'b1;
              end
            end else if (bus.cfg_dat[4]) begin
              abort_d[i] = 1'b1;
            end
          end
          default: ;
        endcase
      end
      if (!busy_d[i]) abort_d[i] = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      gnt_q       <= 2'd0;
      ptr_q       <= 2'd0;
      lat_q       <= 3'd0;
      mem_addr_q  <= '0;
      mem_do_q    <= 8'd0;
      rd_dat_q    <= 8'd0;
      stream_ch_q <= 2'd0;
      busy_q      <= '0;
      done_q      <= '0;
      dir_q       <= '0;
      abort_q     <= '0;
`ifdef MAP_DMA_FILL_EN
      fill_q      <= '0;
`endif
      for (int i = 0; i < CH_MAX; i++) begin
        addr_q[i] <= '0;
        len_q[i]  <= '0;
        tgt_q[i]  <= 2'd0;
`ifdef MAP_DMA_FILL_EN
        fdat_q[i] <= 8'd0;
`endif
      end
    end else begin
      state_q     <= state_d;
      gnt_q       <= gnt_d;
      ptr_q       <= ptr_d;
      lat_q       <= lat_d;
      mem_addr_q  <= mem_addr_d;
      mem_do_q    <= mem_do_d;
      rd_dat_q    <= rd_dat_d;
      stream_ch_q <= stream_ch_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      dir_q       <= dir_d;
      abort_q     <= abort_d;
`ifdef MAP_DMA_FILL_EN
      fill_q      <= fill_d;
`endif
      for (int i = 0; i < CH_MAX; i++) begin
        addr_q[i] <= addr_d[i];
        len_q[i]  <= len_d[i];
        tgt_q[i]  <= tgt_d[i];
`ifdef MAP_DMA_FILL_EN
        fdat_q[i] <= fdat_d[i];
`endif
      end
    end
  end

  // Strobes are decoded from the sequencer state so reset drops them at once.
  assign bus.ch_busy    = busy_q[CH_NUM-1:0];
  assign bus.ch_done    = done_q[CH_NUM-1:0];
  assign bus.dma_req    = |busy_q;
  assign bus.wr_rdy     = wr_rdy_w;
  assign bus.rd_vld     = rd_vld_w;
  assign bus.rd_dat     = rd_dat_q;
  assign bus.stream_ch  = stream_ch_q;
  assign bus.mem_addr   = mem_addr_q;
  assign bus.mem_do     = mem_do_q;
  assign bus.mem_ce_prg = acc_w && (tgt_q[gnt_q] == 2'd0);
  assign bus.mem_ce_chr = acc_w && (tgt_q[gnt_q] == 2'd1);
  assign bus.mem_ce_srm = acc_w && (tgt_q[gnt_q] == 2'd2);
  assign bus.mem_oe     = acc_w && !dir_q[gnt_q];
  assign bus.mem_we     = acc_w &&  dir_q[gnt_q];
endmodule
`default_nettype wire

// File: tb/tb_map_dma_eng.sv
`default_nettype none
// ============================================================================
// Module   : tb_map_dma_eng
// Purpose  : Directed self-checking bench for map_dma_eng. Expected memory
//            accesses and read beats are queued when stimulus is issued and
//            compared by a bus monitor as the engine performs them.
// Revision : 1.0 - initial release
// ============================================================================
module tb_map_dma_eng;
  localparam int CH_NUM  = 2;
  localparam int AW      = 23;
  localparam int LW      = 16;
  localparam int MEM_LAT = 2;
  localparam logic [2:0] CE_PRG = 3'b001, CE_CHR = 3'b010, CE_SRM = 3'b100;

  typedef struct {
    bit         we;
    logic [2:0] ce;
    logic [22:0] addr;
    logic [7:0] dat;
    logic [1:0] ch;
  } acc_t;
  typedef struct {
    logic [7:0] dat;
    logic [1:0] ch;
  } beat_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;
  bit   mon_en = 1'b0;
  acc_t  acc_q[$];
  beat_t rd_q[$];

  map_dma_eng_if #(.CH_NUM(CH_NUM), .AW(AW)) bus ();

  map_dma_eng #(.CH_NUM(CH_NUM), .AW(AW), .LW(LW), .MEM_LAT(MEM_LAT)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // Memory read model: data is a fixed function of the address.
  assign bus.mem_di = bus.mem_addr[7:0] ^ 8'h3C;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic cfg_write(input logic [1:0] ch, input logic [1:0] rg, input logic [23:0] d);
    bus.cfg_we  = 1'b1;
    bus.cfg_ch  = ch;
    bus.cfg_reg = rg;
    bus.cfg_dat = d;
    tick();
    bus.cfg_we  = 1'b0;
  endtask

  task automatic exp_acc(input bit we, input logic [2:0] ce, input logic [22:0] a,
                         input logic [7:0] d, input logic [1:0] ch);
    acc_t  e;
    beat_t b;
    e.we = we; e.ce = ce; e.addr = a; e.dat = d; e.ch = ch;
    acc_q.push_back(e);
    if (!we) begin
      b.dat = a[7:0] ^ 8'h3C;
      b.ch  = ch;
      rd_q.push_back(b);
    end
  endtask

  task automatic wait_idle(input string tag);
    int n = 0;
    while (bus.dma_req && n < 500) begin
      tick();
      n++;
    end
    chk(tag, 32'(n < 500), 1);
  endtask

  task automatic wait_wr_rdy(input string tag);
    int n = 0;
    while (!bus.wr_rdy && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk(tag, 32'(n < 100), 1);
  endtask

  task automatic send_byte(input logic [7:0] d);
    int n = 0;
    bus.wr_dat = d;
    bus.wr_vld = 1'b1;
    while (!bus.wr_rdy && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("send_timeout", 32'(n < 100), 1);
    tick();
    bus.wr_vld = 1'b0;
  endtask

  // Bus monitor: strobe/CE consistency every cycle, access and beat scoring.
  initial begin
    bit    prev;
    bit    strobe;
    int    width;
    acc_t  cur;
    acc_t  e;
    beat_t b;
    prev = 1'b0;
    width = 0;
    forever begin
      @(negedge clk);
      if (!mon_en || rst) begin
        prev  = 1'b0;
        width = 0;
      end else begin
        strobe = bus.mem_oe || bus.mem_we;
        chk("ce_vs_strobe", 32'(bus.mem_ce_prg || bus.mem_ce_chr || bus.mem_ce_srm), 32'(strobe));
        chk("oe_we_excl", 32'(bus.mem_oe && bus.mem_we), 0);
        if (strobe && !prev) begin
          cur.we   = bus.mem_we;
          cur.ce   = {bus.mem_ce_srm, bus.mem_ce_chr, bus.mem_ce_prg};
          cur.addr = bus.mem_addr;
          cur.dat  = bus.mem_do;
          cur.ch   = bus.stream_ch;
          width    = 1;
        end else if (strobe) begin
          width++;
        end else if (prev) begin
          chk("acc_expected", 32'(acc_q.size() != 0), 1);
          if (acc_q.size() != 0) begin
            e = acc_q.pop_front();
            chk("acc_we", 32'(cur.we), 32'(e.we));
            chk("acc_ce", 32'(cur.ce), 32'(e.ce));
            chk("acc_addr", 32'(cur.addr), 32'(e.addr));
            chk("acc_ch", 32'(cur.ch), 32'(e.ch));
            if (e.we) chk("acc_wdat", 32'(cur.dat), 32'(e.dat));
          end
          chk("acc_width", 32'(width), 32'(MEM_LAT));
        end
        prev = strobe;
        if (bus.rd_vld && bus.rd_rdy) begin
          chk("beat_expected", 32'(rd_q.size() != 0), 1);
          if (rd_q.size() != 0) begin
            b = rd_q.pop_front();
            chk("beat_dat", 32'(bus.rd_dat), 32'(b.dat));
            chk("beat_ch", 32'(bus.stream_ch), 32'(b.ch));
          end
        end
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int seen;
    bus.cfg_we = 1'b0; bus.cfg_ch = 2'd0; bus.cfg_reg = 2'd0; bus.cfg_dat = 24'd0;
    bus.wr_dat = 8'd0; bus.wr_vld = 1'b0; bus.rd_rdy = 1'b0;

    // Reset state.
    tick(3);
    chk("rst_busy", 32'(bus.ch_busy), 0);
    chk("rst_done", 32'(bus.ch_done), 0);
    chk("rst_dma_req", 32'(bus.dma_req), 0);
    chk("rst_mem_addr", 32'(bus.mem_addr), 0);
    chk("rst_strobes", 32'({bus.mem_ce_prg, bus.mem_ce_chr, bus.mem_ce_srm, bus.mem_oe, bus.mem_we}), 0);
    chk("rst_stream", 32'({bus.wr_rdy, bus.rd_vld, bus.rd_dat, bus.stream_ch, bus.mem_do}), 0);
    rst = 1'b0;
    tick();

    // Reset in the middle of an access.
    cfg_write(2'd0, 2'd0, 24'h000005);
    cfg_write(2'd0, 2'd1, 24'd2);
    cfg_write(2'd0, 2'd2, 24'h000001);
    n = 0;
    while (!bus.mem_ce_prg && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("midacc_ce_seen", 32'(n < 50), 1);
    #1 rst = 1'b1;
    #1;
    chk("midacc_ce", 32'({bus.mem_ce_prg, bus.mem_ce_chr, bus.mem_ce_srm}), 0);
    chk("midacc_oe_we", 32'({bus.mem_oe, bus.mem_we}), 0);
    chk("midacc_busy", 32'({bus.ch_busy, bus.dma_req}), 0);
    chk("midacc_addr", 32'(bus.mem_addr), 0);
    @(posedge clk);
    #1 rst = 1'b0;
    tick();
    chk("post_rst_busy", 32'(bus.ch_busy), 0);
    chk("post_rst_req", 32'(bus.dma_req), 0);
    mon_en = 1'b1;

    // Degenerate starts and config corner cases.
    cfg_write(2'd0, 2'd1, 24'd0);
    cfg_write(2'd0, 2'd2, 24'h000001);
    chk("len0_done", 32'(bus.ch_done[0]), 1);
    chk("len0_busy", 32'(bus.ch_busy), 0);
    cfg_write(2'd1, 2'd1, 24'd4);
    cfg_write(2'd1, 2'd2, 24'h00000D);
    chk("tgt3_done", 32'(bus.ch_done[1]), 1);
    chk("tgt3_busy", 32'(bus.dma_req), 0);
    cfg_write(2'd0, 2'd2, 24'h000000);
    chk("ctrl_clears_done", 32'(bus.ch_done), 32'b10);
    cfg_write(2'd2, 2'd1, 24'd5);
    cfg_write(2'd2, 2'd2, 24'h000001);
    tick();
    chk("bad_ch_ignored", 32'({bus.dma_req, bus.ch_done}), 32'b010);

    // Read on ch0 from CHR with address wrap.
    bus.rd_rdy = 1'b1;
    cfg_write(2'd0, 2'd0, 24'h7FFFFE);
    cfg_write(2'd0, 2'd1, 24'd3);
    exp_acc(1'b0, CE_CHR, 23'h7FFFFE, 8'h00, 2'd0);
    exp_acc(1'b0, CE_CHR, 23'h7FFFFF, 8'h00, 2'd0);
    exp_acc(1'b0, CE_CHR, 23'h000000, 8'h00, 2'd0);
    cfg_write(2'd0, 2'd2, 24'h000005);
    chk("rd_busy", 32'(bus.dma_req), 1);
    wait_idle("rd_timeout");
    tick(2);
    chk("rd_done", 32'(bus.ch_done[0]), 1);
    chk("rd_req_low", 32'(bus.dma_req), 0);
    chk("rd_all_acc", 32'(acc_q.size()), 0);
    chk("rd_all_beats", 32'(rd_q.size()), 0);

    // Write on ch1 to SRM with a starved stream.
    cfg_write(2'd1, 2'd0, 24'h000100);
    cfg_write(2'd1, 2'd1, 24'd2);
    exp_acc(1'b1, CE_SRM, 23'h000100, 8'h11, 2'd1);
    exp_acc(1'b1, CE_SRM, 23'h000101, 8'h22, 2'd1);
    cfg_write(2'd1, 2'd2, 24'h00000B);
    wait_wr_rdy("wr_rdy_timeout");
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("stall_wr_rdy", 32'(bus.wr_rdy), 1);
      chk("stall_no_we", 32'(bus.mem_we), 0);
    end
    send_byte(8'h11);
    send_byte(8'h22);
    wait_idle("wr_timeout");
    tick(2);
    chk("wr_done", 32'(bus.ch_done[1]), 1);
    chk("wr_all_acc", 32'(acc_q.size()), 0);

    // Both channels active: accesses must alternate.
    cfg_write(2'd0, 2'd0, 24'h000010);
    cfg_write(2'd0, 2'd1, 24'd2);
    cfg_write(2'd1, 2'd0, 24'h000020);
    cfg_write(2'd1, 2'd1, 24'd2);
    exp_acc(1'b0, CE_PRG, 23'h000010, 8'h00, 2'd0);
    exp_acc(1'b0, CE_PRG, 23'h000020, 8'h00, 2'd1);
    exp_acc(1'b0, CE_PRG, 23'h000011, 8'h00, 2'd0);
    exp_acc(1'b0, CE_PRG, 23'h000021, 8'h00, 2'd1);
    cfg_write(2'd0, 2'd2, 24'h000001);
    cfg_write(2'd1, 2'd2, 24'h000001);
    chk("rr_both_busy", 32'(bus.ch_busy), 32'b11);
    wait_idle("rr_timeout");
    tick(2);
    chk("rr_done", 32'(bus.ch_done), 32'b11);
    chk("rr_all_acc", 32'(acc_q.size()), 0);

    // Abort ch0 while its beat is held.
    bus.rd_rdy = 1'b0;
    cfg_write(2'd0, 2'd0, 24'h000040);
    cfg_write(2'd0, 2'd1, 24'd5);
    exp_acc(1'b0, CE_PRG, 23'h000040, 8'h00, 2'd0);
    cfg_write(2'd0, 2'd2, 24'h000001);
    n = 0;
    while (!bus.rd_vld && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("hold_seen", 32'(n < 50), 1);
    tick();
    cfg_write(2'd0, 2'd2, 24'h000010);
    tick(3);
    chk("hold_vld", 32'(bus.rd_vld), 1);
    chk("hold_dat", 32'(bus.rd_dat), 32'h40 ^ 32'h3C);
    bus.rd_rdy = 1'b1;
    wait_idle("abort_hold_timeout");
    chk("abort_done", 32'(bus.ch_done[0]), 1);
    chk("abort_busy", 32'(bus.ch_busy), 0);
    tick(10);
    chk("abort_acc", 32'(acc_q.size()), 0);
    chk("abort_beats", 32'(rd_q.size()), 0);

    // Abort ch1 while starved in WAIT_WR.
    cfg_write(2'd1, 2'd0, 24'h000300);
    cfg_write(2'd1, 2'd1, 24'd3);
    cfg_write(2'd1, 2'd2, 24'h00000B);
    wait_wr_rdy("abort_wr_rdy");
    tick();
    cfg_write(2'd1, 2'd2, 24'h000010);
    wait_idle("abort_wr_timeout");
    tick(5);
    chk("abort_wr_done", 32'(bus.ch_done[1]), 1);
    chk("abort_wr_busy", 32'(bus.dma_req), 0);

    // Constant fill (or stream write when the fill option is absent).
    cfg_write(2'd0, 2'd0, 24'h000200);
    cfg_write(2'd0, 2'd1, 24'd4);
`ifdef MAP_DMA_FILL_EN
    for (int i = 0; i < 4; i++) exp_acc(1'b1, CE_PRG, 23'(32'h200 + i), 8'hA5, 2'd0);
    cfg_write(2'd0, 2'd2, 24'h00A523);
    n = 0;
    seen = 0;
    while (bus.dma_req && n < 500) begin
      @(negedge clk);
      if (bus.wr_rdy) seen++;
      n++;
    end
    chk("fill_timeout", 32'(n < 500), 1);
    chk("fill_no_wr_rdy", 32'(seen), 0);
    tick(2);
`else
    seen = 0;
    for (int i = 0; i < 4; i++) exp_acc(1'b1, CE_PRG, 23'(32'h200 + i), 8'(8'h31 + i), 2'd0);
    cfg_write(2'd0, 2'd2, 24'h00A523);
    for (int i = 0; i < 4; i++) send_byte(8'(8'h31 + i));
    wait_idle("fillstream_timeout");
    tick(2);
`endif
    chk("fill_done", 32'(bus.ch_done[0]), 1);
    chk("fill_all_acc", 32'(acc_q.size()), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
`default_nettype wire

// File: doc/map_dma_eng.md
Name: map_dma_eng

Overview:
- Multi-channel, parametrised DMA engine for mapper-side block transfers.
- Moves byte streams between a host-side stream port and PRG/CHR/SRM memories.
- Each channel has its own address, length, target, and direction.
- Serviced channels are interleaved per access under round-robin arbitration, and dma_req is raised while any channel is active.

Parameters:
- CH_NUM, 2: number of channels, 1..4.
- AW, 23: memory address width.
- LW, 16: transfer length counter width, in bytes.
- MEM_LAT, 2: cycles the CE strobe and the OE/WE strobe are held per access, 1..7.

Ports:
- clk  in  1  system clock.
- rst  in  1  reset; asynchronous, active-high.
- cfg_we  in  1  config write strobe, one cycle.
- cfg_ch  in  2  channel index. Index ≥ CH_NUM: write ignored.
- cfg_reg  in  2  register select: 0 addr, 1 len, 2 ctrl, 3 reserved (ignored).
- cfg_dat  in  24  config data.
- ch_busy  out  CH_NUM  per-channel active flag.
- ch_done  out  CH_NUM  sticky completion flag.
- wr_dat  in  8  stream-to-memory data.
- wr_vld  in  1  wr_dat valid.
- wr_rdy  out  1  wr_dat accepted when wr_vld&wr_rdy.
- rd_dat  out  8  memory-to-stream data.
- rd_vld  out  1  rd_dat valid.
- rd_rdy  in  1  consumer ready.
- stream_ch  out  2  channel owning the current stream beat.
- mem_addr  out  AW  memory address.
- mem_do  out  8  write data.
- mem_di  in  8  read data, sampled on the last ACC cycle.
- mem_ce_prg  out  1  PRG chip enable.
- mem_ce_chr  out  1  CHR chip enable.
- mem_ce_srm  out  1  SRM chip enable.
- mem_oe  out  1  read strobe.
- mem_we  out  1  write strobe.
- dma_req  out  1  OR of ch_busy.

Behaviour:
- Reset: every output 0, every channel register 0, FSM to IDLE. Reset acts immediately, including mid-access.
- Register writes:
  - addr ← cfg_dat[AW-1:0].
  - len ← cfg_dat[LW-1:0].
  - ctrl bits: [0] start, [1] dir (0 mem→rd stream, 1 wr stream→mem), [3:2] target (0 PRG, 1 CHR, 2 SRM, 3 invalid), [4] abort.
  - Any ctrl write clears that channel's ch_done.
  - addr/len writes to a busy channel are ignored.
- Start handling (start=1 on an idle channel):
  - len==0 or target==3: ch_done←1 next cycle, no memory access, never busy.
  - Otherwise ch_busy←1.
  - start on an already-busy channel is ignored.
- FSM per access:
  - IDLE: if any channel is busy, go to ARB.
  - ARB (1 cycle): grant the next busy channel after the last granted, round-robin. Set stream_ch; set mem_addr to the channel's address.
  - Write direction, WAIT_WR: wr_rdy=1 until wr_vld. Latch mem_do, go to ACC.
  - Read direction: go straight to ACC.
  - ACC (MEM_LAT cycles): the selected CE is high together with mem_oe (read) or mem_we (write).
    - Read: capture mem_di on the last cycle, go to HOLD.
    - Write: go to NEXT.
  - HOLD: rd_vld=1, rd_dat stable until rd_rdy, then go to NEXT.
  - NEXT (1 cycle):
    - addr ← addr+1, wrapping at 2^AW.
    - len ← len−1.
    - If len reaches 0 or abort is pending: ch_busy←0, ch_done←1.
    - Return to IDLE.
- Control strobes: CE/OE/WE are never active outside ACC; OE and WE are never high together.
- Per-access latency, no back-pressure:
  - Read: 1 (ARB) + MEM_LAT + 1 (HOLD) + 1 (NEXT) cycles.
  - Write: 1 (ARB) + 1 (WAIT_WR) + MEM_LAT + 1 (NEXT) cycles.
- Abort:
  - On an idle channel: clears done only.
  - On a busy channel: sets a pending flag. The in-flight access, including its HOLD/WAIT_WR, completes; then the channel ends with done=1.
  - Abort while a channel waits in WAIT_WR with wr_vld=0: leave WAIT_WR without any access and finish immediately.
- Simultaneous events:
  - cfg write and NEXT updating the same channel: NEXT's update wins for addr/len, ctrl still applies.
  - Done set and ctrl clear in the same cycle: clear wins.

Optional Feature:
- Macro MAP_DMA_FILL_EN.
- When defined: ctrl[5]=fill together with dir=1 writes the constant ctrl[15:8] to memory. WAIT_WR is skipped and wr_rdy stays 0 for that channel; write latency drops by 1 cycle.
- When not defined: ctrl[5] and ctrl[15:8] are ignored, and all writes use the stream.

Test Plan:
- rst mid-ACC with CE high → all outputs 0 in the same cycle. After release, channels are idle and dma_req=0.
- Read, ch0, CHR target:
  - Stimulus: addr=0x7FFFFE, len=3, AW=23, rd_rdy tied 1.
  - Required: mem_addr sequence 0x7FFFFE, 0x7FFFFF, 0x000000 (wrap); 3 beats on rd_vld; then ch_done[0]=1, dma_req=0.
- Write, ch1, SRM target:
  - Stimulus: len=2, wr_vld stalled for 5 cycles.
  - Required: wr_rdy stays high; no mem_we during the stall; 2 writes total with mem_we pulse width MEM_LAT.
- Both channels started in the same cycle, len=2 each → accesses alternate ch0, ch1, ch0, ch1, with stream_ch matching.
- Abort ch0 while in HOLD with rd_rdy=0 → the beat is still delivered once rd_rdy=1; then done=1 with remaining len>0, and no further access.
- MAP_DMA_FILL_EN defined: fill 0xA5, len=4 on PRG → 4 writes of 0xA5, wr_rdy never 1. Repeat with the macro undefined → the stream is used.
